// File: rtl/icache_pkg.sv
// Shared defaults, derived widths and small helpers for the N-way instruction cache set.
package icache_pkg;

    localparam int B_DEF            = 64;
    localparam int E_DEF            = 4;
    localparam int NUM_TAG_BITS_DEF = 26;

    // Index width never drops to zero so a direct-mapped set still has a 1-bit way index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int OFFSET_W = $clog2(B_DEF);
    localparam int WAY_W    = idx_w(E_DEF);
    localparam int AGE_W    = WAY_W;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hffff_ffff) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_lru.sv
// Per-way age tracking (0 = MRU, E-1 = LRU) and victim selection for one cache set.
module icache_lru
    import icache_pkg::*;
#(
    parameter int E = E_DEF,
    localparam int WW = idx_w(E)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 access,
    input  logic [WW-1:0]        access_way,
    input  logic                 flush,
    input  logic [E-1:0]         valid,
    output logic [WW-1:0]        victim_way,
    output logic [E-1:0][WW-1:0] ages
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < E; i++) ages[i] <= WW'(i);
        end else if (access) begin
            for (int i = 0; i < E; i++) begin
                if (WW'(i) == access_way)
                    ages[i] <= '0;
                else if (ages[i] < ages[access_way])
                    ages[i] <= ages[i] + 1'b1;
            end
        end
    end

    // Lowest-index invalid way wins; otherwise the LRU way.
    always_comb begin
        victim_way = '0;
        for (int i = E - 1; i >= 0; i--)
            if (ages[i] == WW'(E - 1)) victim_way = WW'(i);
        for (int i = E - 1; i >= 0; i--)
            if (!valid[i]) victim_way = WW'(i);
    end

endmodule

// File: rtl/icache_set_nway.sv
// One set of an E-way instruction cache: flop storage, same-cycle lookup, LRU fill.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_set_nway
    import icache_pkg::*;
#(
    parameter int B            = B_DEF,
    parameter int E            = E_DEF,
    parameter int NUM_TAG_BITS = NUM_TAG_BITS_DEF,
    localparam int OW  = $clog2(B),
    localparam int WW  = idx_w(E),
    localparam int WIW = idx_w(B / 4)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    active_set,
    input  logic                    flush,
    input  logic                    rep_ready,
    input  logic [OW-1:0]           block,
    input  logic [NUM_TAG_BITS-1:0] tag,
    input  logic [B*8-1:0]          rep_block,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count,
`endif
    output logic [31:0]             data,
    output logic                    cache_miss,
    output logic [WW-1:0]           hit_way
);

    logic [E-1:0]            valid;
    logic [NUM_TAG_BITS-1:0] tags   [E];
    logic [B*8-1:0]          blocks [E];
    logic [E-1:0]            match;
    logic [WW-1:0]           way_sel;
    logic [WW-1:0]           victim;
    logic [E-1:0][WW-1:0]    ages;
    logic [WIW-1:0]          word;
    logic                    hit;
    logic                    fill;
    logic                    access;
    logic                    unused_ok;

    always_comb begin
        match   = '0;
        way_sel = '0;
        for (int i = E - 1; i >= 0; i--) begin
            if (valid[i] && tags[i] == tag) begin
                match[i] = 1'b1;
                way_sel  = WW'(i);
            end
        end
    end

    generate
        if (B > 4) begin : g_word
            assign word = block[OW-1:2];
        end else begin : g_word1
            assign word = '0;
        end
    endgenerate

    assign unused_ok  = ^block[1:0];
    assign hit        = active_set & (|match);
    assign cache_miss = ~hit;
    assign hit_way    = hit ? way_sel : '0;
    assign data       = hit ? blocks[way_sel][{word, 5'b0} +: 32] : 32'd0;
    assign fill       = active_set & ~hit & rep_ready & ~flush;
    assign access     = (active_set & hit) | fill;

    icache_lru #(.E(E)) u_lru (
        .clk        (clk),
        .reset      (reset),
        .access     (access),
        .access_way (hit ? way_sel : victim),
        .flush      (flush),
        .valid      (valid),
        .victim_way (victim),
        .ages       (ages)
    );

    always_ff @(posedge clk) begin
        if (reset || flush)
            valid <= '0;
        else if (fill)
            valid[victim] <= 1'b1;
    end

    // Payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fill) begin
            tags[victim]   <= tag;
            blocks[victim] <= rep_block;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (active_set && hit) hit_count  <= sat_inc(hit_count);
            if (fill)              miss_count <= sat_inc(miss_count);
        end
    end
`endif

endmodule

// File: tb/tb_icache_set_nway.sv
// Directed bench for icache_set_nway (B=64, E=4): fills, re-reads, LRU replacement, flush, reset.
module tb_icache_set_nway;
    import icache_pkg::*;

    logic         clk = 1'b0;
    logic         reset, active_set, flush, rep_ready;
    logic [5:0]   block;
    logic [25:0]  tag;
    logic [511:0] rep_block;
    logic [31:0]  data;
    logic         cache_miss;
    logic [1:0]   hit_way;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_count, miss_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    icache_set_nway dut (
        .clk        (clk),
        .reset      (reset),
        .active_set (active_set),
        .flush      (flush),
        .rep_ready  (rep_ready),
        .block      (block),
        .tag        (tag),
        .rep_block  (rep_block),
`ifdef ICACHE_PERF_CNT_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .data       (data),
        .cache_miss (cache_miss),
        .hit_way    (hit_way)
    );

    function automatic logic [511:0] mkblk(input int seed);
        logic [511:0] b;
        for (int j = 0; j < 64; j++) b[j*8 +: 8] = 8'(seed * 13 + j * 29 + 5);
        return b;
    endfunction

    function automatic logic [7:0] ag(input int a0, input int a1, input int a2, input int a3);
        return {2'(a3), 2'(a2), 2'(a1), 2'(a0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [511:0] blkv;
    int tg[4]     = '{500, 600, 700, 800};
    int rd_tag[4] = '{800, 700, 600, 500};
    int rd_way[4] = '{3, 2, 1, 0};
    int rd_blk[4] = '{4, 8, 12, 16};
    logic [7:0] fill_ages[4];
    logic [7:0] read_ages[4];

    initial begin
        fill_ages = '{ag(0,1,2,3), ag(1,0,2,3), ag(2,1,0,3), ag(3,2,1,0)};
        read_ages = '{ag(3,2,1,0), ag(3,2,0,1), ag(3,0,1,2), ag(0,1,2,3)};
        reset = 1'b1; active_set = 1'b0; flush = 1'b0; rep_ready = 1'b0;
        block = '0; tag = '0; rep_block = '0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("idle_miss", 64'(cache_miss), 1);
        chk("idle_data", 64'(data), 0);
        chk("idle_hit_way", 64'(hit_way), 0);
        chk("idle_ages", 64'(dut.u_lru.ages), 64'(ag(0,1,2,3)));

        // Four cold fills, each followed by one hit cycle
        for (int k = 0; k < 4; k++) begin
            blkv = mkblk(tg[k]);
            tag = 26'(tg[k]); rep_block = blkv; block = '0;
            active_set = 1'b1; rep_ready = 1'b0;
            #1;
            chk("pre_fill_miss", 64'(cache_miss), 1);
            rep_ready = 1'b1;
            tick();
            rep_ready = 1'b0;
            chk("post_fill_miss", 64'(cache_miss), 0);
            chk("post_fill_way", 64'(hit_way), 64'(k));
            chk("post_fill_data", 64'(data), 64'(blkv[31:0]));
            tick();
            chk("fill_ages", 64'(dut.u_lru.ages), 64'(fill_ages[k]));
        end

        // Re-read in reverse order at different word offsets
        for (int k = 0; k < 4; k++) begin
            blkv = mkblk(rd_tag[k]);
            tag = 26'(rd_tag[k]); block = 6'(rd_blk[k]);
            #1;
            chk("reread_miss", 64'(cache_miss), 0);
            chk("reread_way", 64'(hit_way), 64'(rd_way[k]));
            chk("reread_data", 64'(data), 64'(blkv[rd_blk[k]*8 +: 32]));
            tick();
            chk("reread_ages", 64'(dut.u_lru.ages), 64'(read_ages[k]));
        end
        active_set = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hits_8", 64'(hit_count), 8);
        chk("perf_miss_4", 64'(miss_count), 4);
`endif

        // LRU replacement with rep_ready held for ten cycles
        blkv = mkblk(1000);
        tag = 26'd1000; rep_block = blkv; active_set = 1'b1; rep_ready = 1'b1;
        #1;
        chk("repl_pre_miss", 64'(cache_miss), 1);
        repeat (10) tick();
        rep_ready = 1'b0;
        chk("repl_way", 64'(hit_way), 3);
        chk("repl_data", 64'(data), 64'(blkv[16*8 +: 32]));
        chk("repl_ages", 64'(dut.u_lru.ages), 64'(ag(1,2,3,0)));
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_miss_5", 64'(miss_count), 5);
        chk("perf_hits_17", 64'(hit_count), 17);
`endif
        tag = 26'd800; #1;
        chk("evicted_800_miss", 64'(cache_miss), 1);
        tag = 26'd500; #1;
        chk("kept_500_way", 64'(hit_way), 0);
        tag = 26'd600; #1;
        chk("hit_600_way", 64'(hit_way), 1);
        tick();
        chk("ages_after_600", 64'(dut.u_lru.ages), 64'(ag(2,0,3,1)));

        // Inactive set must ignore everything but flush
        active_set = 1'b0; rep_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tag = 26'($urandom); block = 6'($urandom);
            tick();
        end
        chk("inactive_miss", 64'(cache_miss), 1);
        chk("inactive_data", 64'(data), 0);
        chk("inactive_hit_way", 64'(hit_way), 0);
        chk("inactive_ages", 64'(dut.u_lru.ages), 64'(ag(2,0,3,1)));
        rep_ready = 1'b0; active_set = 1'b1; tag = 26'd600; #1;
        chk("still_600_way", 64'(hit_way), 1);
        tag = 26'd1000; #1;
        chk("still_1000_hit", 64'(cache_miss), 0);

        // Flush wins over a pending fill
        tag = 26'd2000; rep_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; rep_ready = 1'b0;
        chk("flush_2000_miss", 64'(cache_miss), 1);
        chk("flush_data", 64'(data), 0);
        chk("flush_ages", 64'(dut.u_lru.ages), 64'(ag(0,1,2,3)));
        tag = 26'd600; #1;
        chk("flush_600_miss", 64'(cache_miss), 1);
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_miss_flush", 64'(miss_count), 5);
`endif

        // Reset wins over a hit with rep_ready high
        blkv = mkblk(3000);
        tag = 26'd3000; rep_block = blkv; rep_ready = 1'b1;
        tick();
        rep_ready = 1'b0;
        chk("refill_way0", 64'(hit_way), 0);
        chk("refill_hit", 64'(cache_miss), 0);
        reset = 1'b1; rep_ready = 1'b1;
        tick();
        reset = 1'b0; rep_ready = 1'b0;
        chk("reset_miss", 64'(cache_miss), 1);
        chk("reset_data", 64'(data), 0);
        chk("reset_ages", 64'(dut.u_lru.ages), 64'(ag(0,1,2,3)));
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_reset_hits", 64'(hit_count), 0);
        chk("perf_reset_miss", 64'(miss_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
